// File: rtl/ofdm_spi_master.sv
// ---------------------------------------------------------------------------
// ofdm_spi_master
//
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex. Drives the
// OFDM transmitter's external SPI slave port from an FPGA-fabric control
// source. One tx word is shifted out on mosi while one rx word is captured
// from miso.
//
// Parameters
//   DATA_W   bits per SPI word (>= 2)
//   CLK_DIV  clk cycles per sclk half-period (>= 1)
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   tx_data   in   word to send, MSB first (sampled only at accept)
//   tx_valid  in   tx_data valid
//   tx_ready  out  word accepted when tx_valid & tx_ready
//   rx_data   out  last word captured from miso, held until next capture
//   rx_valid  out  one-cycle pulse when rx_data is updated (no backpressure)
//   busy      out  high whenever the engine is not idle
//   sclk      out  SPI clock, idle low (registered)
//   mosi      out  SPI data out (registered)
//   miso      in   SPI data in
//   nss       out  slave select, active low (registered)
//
// Configuration macro
//   SPI_MASTER_BURST_EN  when defined, a new word may be accepted in the last
//                        HOLD cycle; the next frame then starts with nss held
//                        low and no GAP. When undefined, every word gets its
//                        own nss low period followed by a GAP.
//
// Frame timing: SETUP (CLK_DIV) + DATA_W bits of 2*CLK_DIV + HOLD (CLK_DIV)
// with nss low, then GAP (CLK_DIV) with nss high, then one IDLE cycle.
// ---------------------------------------------------------------------------
module ofdm_spi_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              nss
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    state_t             state;
    logic [CNT_W-1:0]   cnt;       // cycles elapsed in the current half-period/phase
    logic [BIT_W-1:0]   bit_cnt;   // index of the bit currently on the wire
    logic [DATA_W-1:0]  tx_sr;
    logic [DATA_W-1:0]  rx_sr;

    logic phase_end;
    logic last_bit;
    logic last_hold;
    logic enter_last_hold;
    logic burst_slot;
    logic accept;

    assign phase_end = (cnt == CNT_W'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
    assign last_hold = (state == HOLD) && phase_end;

    // rx_valid is a register that must be high during the last HOLD cycle,
    // so it is set on the edge that enters that cycle. With CLK_DIV == 1 the
    // HOLD phase is a single cycle entered straight from the last SHIFT cycle.
    generate
        if (CLK_DIV == 1) begin : g_div1
            assign enter_last_hold = (state == SHIFT) && !sclk && phase_end && last_bit;
        end else begin : g_divn
            assign enter_last_hold = (state == HOLD) && (cnt == CNT_W'(CLK_DIV - 2));
        end
    endgenerate

`ifdef SPI_MASTER_BURST_EN
    assign burst_slot = last_hold;
`else
    assign burst_slot = 1'b0;
`endif

    assign tx_ready = !reset && ((state == IDLE) || burst_slot);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != IDLE);

    // NOTE: all state and outputs below use non-blocking assignments so every
    // register samples the pre-edge values; blocking here would chain updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            nss      <= 1'b1;
        end else begin
            rx_valid <= enter_last_hold;
            if (enter_last_hold) begin
                rx_data <= rx_sr;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        tx_sr <= tx_data;
                        mosi  <= tx_data[DATA_W-1];
                        nss   <= 1'b0;
                        state <= SETUP;
                    end
                end

                SETUP: begin
                    if (phase_end) begin
                        // First rising sclk edge: slave has had a full
                        // half-period to see the MSB, so sample miso now.
                        cnt     <= '0;
                        bit_cnt <= '0;
                        sclk    <= 1'b1;
                        rx_sr   <= {rx_sr[DATA_W-2:0], miso};
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (!phase_end) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (sclk) begin
                            // Falling edge: present the next bit, except after
                            // the last one where mosi is left untouched.
                            sclk <= 1'b0;
                            if (!last_bit) begin
                                tx_sr <= tx_sr << 1;
                                mosi  <= tx_sr[DATA_W-2];
                            end
                        end else if (last_bit) begin
                            state <= HOLD;
                        end else begin
                            sclk    <= 1'b1;
                            rx_sr   <= {rx_sr[DATA_W-2:0], miso};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                HOLD: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (accept) begin
                            // Back-to-back word: keep nss low, skip GAP.
                            tx_sr <= tx_data;
                            mosi  <= tx_data[DATA_W-1];
                            state <= SETUP;
                        end else begin
                            nss   <= 1'b1;
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    cnt   <= '0;
                    sclk  <= 1'b0;
                    nss   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_spi_master.sv
// ---------------------------------------------------------------------------
// tb_ofdm_spi_master
//
// Self-checking bench for ofdm_spi_master with DATA_W=16, CLK_DIV=2.
// Expected rx words are pushed to a scoreboard queue when a word is accepted
// and popped/compared when rx_valid pulses. A negedge monitor measures nss
// low/high run lengths, sclk rising edges, the mosi bit stream and the
// spacing of accepts and rx_valid pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ofdm_spi_master;

    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 2;
    localparam int LOW_LEN = (2 * DATA_W + 2) * CLK_DIV;       // 68
    localparam int PERIOD  = (2 * DATA_W + 3) * CLK_DIV + 1;   // 71

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              nss;

    int miso_mode;  // 0: loop from mosi, 1: tied high, 2: tied low
    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    ofdm_spi_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .nss      (nss)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and monitor state
    logic [DATA_W-1:0] sb[$];
    int          cyc = 0;
    int          accept_cnt = 0;
    int          last_acc, last_rxv, rxv_period;
    bit          check_period;
    int          rise_cnt, rxv_cnt, lows_cnt;
    int          low_len, high_len, last_low, min_low, max_low, min_high;
    logic [31:0] mosi_bits;
    logic        prev_sclk = 1'b0;

    task automatic clear_mon();
        rise_cnt     = 0;
        rxv_cnt      = 0;
        lows_cnt     = 0;
        low_len      = 0;
        high_len     = 0;
        last_low     = 0;
        min_low      = 1_000_000;
        max_low      = 0;
        min_high     = 1_000_000;
        mosi_bits    = '0;
        last_acc     = -1;
        last_rxv     = -1;
        rxv_period   = 0;
        check_period = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            sb.delete();  // partial word in flight is discarded
        end else begin
            if (tx_valid && tx_ready) begin
                accept_cnt++;
                if (check_period && last_acc >= 0)
                    check("accept_period", cyc - last_acc, PERIOD);
                last_acc = cyc;
                sb.push_back((miso_mode == 0) ? tx_data : (miso_mode == 1) ? '1 : '0);
            end
            if (rx_valid) begin
                rxv_cnt++;
                if (last_rxv >= 0) rxv_period = cyc - last_rxv;
                last_rxv = cyc;
                if (sb.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", rx_data, sb.pop_front());
            end
        end
        if (sclk && !prev_sclk) begin
            rise_cnt++;
            mosi_bits = {mosi_bits[30:0], mosi};
        end
        prev_sclk = sclk;
        if (!nss) begin
            if (high_len > 0 && lows_cnt > 0 && high_len < min_high) min_high = high_len;
            high_len = 0;
            low_len++;
        end else begin
            if (low_len > 0) begin
                lows_cnt++;
                last_low = low_len;
                if (low_len < min_low) min_low = low_len;
                if (low_len > max_low) max_low = low_len;
            end
            low_len = 0;
            high_len++;
        end
    end

    // Called from a point just after a posedge; waits for the accept count.
    task automatic wait_accept(input int n);
        int k = 0;
        while (accept_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (accept_cnt < n) check("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_accept(accept_cnt + 1);
        @(posedge clk);
        #2;
        tx_valid = 1'b0;
        tx_data  = DATA_W'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (busy || sb.size() != 0) check("idle_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    int acc_before;
    int rxv_before;

    initial begin
        reset     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = '0;
        miso_mode = 0;
        clear_mon();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_nss", nss, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("idle_tx_ready", tx_ready, 1);
        @(posedge clk);
        #2;

        // 1. Single loopback word
        clear_mon();
        send(16'hA5C3);
        wait_idle();
        check("t1_nss_low", last_low, LOW_LEN);
        check("t1_nss_pulses", lows_cnt, 1);
        check("t1_rises", rise_cnt, DATA_W);
        check("t1_mosi_bits", mosi_bits[15:0], 16'hA5C3);
        check("t1_rx_pulses", rxv_cnt, 1);

        // 2. miso tied high / low
        miso_mode = 1;
        send(16'h0000);
        wait_idle();
        check("t2_rx_hi", rx_data, 16'hFFFF);
        miso_mode = 2;
        send(16'hFFFF);
        wait_idle();
        check("t2_rx_lo", rx_data, 16'h0000);
        miso_mode = 0;

`ifdef SPI_MASTER_BURST_EN
        // 5. Two words back to back in one nss frame
        clear_mon();
        tx_valid   = 1'b1;
        tx_data    = 16'h1E2D;
        acc_before = accept_cnt;
        wait_accept(acc_before + 1);
        @(posedge clk);
        #2 tx_data = 16'hC0DE;
        wait_accept(acc_before + 2);
        @(posedge clk);
        #2 tx_valid = 1'b0;
        wait_idle();
        check("t5_nss_pulses", lows_cnt, 1);
        check("t5_nss_low", last_low, 2 * LOW_LEN);
        check("t5_rises", rise_cnt, 2 * DATA_W);
        check("t5_rx_pulses", rxv_cnt, 2);
        check("t5_rx_period", rxv_period, LOW_LEN);
        check("t5_mosi_bits", mosi_bits, 32'h1E2DC0DE);
`else
        // 3. tx_valid held high for three words
        clear_mon();
        check_period = 1'b1;
        tx_valid     = 1'b1;
        acc_before   = accept_cnt;
        for (int i = 0; i < 3; i++) begin
            tx_data = DATA_W'(16'h3C00 + i * 16'h0111);
            wait_accept(acc_before + i + 1);
            @(posedge clk);
            #2;
        end
        tx_valid = 1'b0;
        wait_idle();
        check_period = 1'b0;
        check("t3_nss_pulses", lows_cnt, 3);
        check("t3_min_low", min_low, LOW_LEN);
        check("t3_max_low", max_low, LOW_LEN);
        check("t3_gap_ge2", (min_high >= 2), 1);
        check("t3_rx_pulses", rxv_cnt, 3);
`endif

        // 4. Reset in the middle of bit 7
        clear_mon();
        tx_data  = 16'h1234;
        tx_valid = 1'b1;
        wait_accept(accept_cnt + 1);
        @(posedge clk);
        #2 tx_valid = 1'b0;
        begin
            int k = 0;
            while (rise_cnt < 8 && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        check("t4_reached_bit7", rise_cnt, 8);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_nss", nss, 1);
        check("t4_sclk", sclk, 0);
        check("t4_busy", busy, 0);
        check("t4_tx_ready", tx_ready, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (80) @(posedge clk);
        #2;
        check("t4_no_rx_valid", rxv_cnt, 0);
        clear_mon();
        send(16'h5A3C);
        wait_idle();
        check("t4_after_rx_pulses", rxv_cnt, 1);
        check("t4_after_rx", rx_data, 16'h5A3C);

        // 6. tx_valid pulsed while busy is ignored
        clear_mon();
        send(16'h0F0F);
        acc_before = accept_cnt;
        repeat (10) @(posedge clk);
        #2;
        tx_data  = 16'hDEAD;
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_tx_ready_busy", tx_ready, 0);
        end
        @(posedge clk);
        #2 tx_valid = 1'b0;
        wait_idle();
        check("t6_no_accept", accept_cnt, acc_before);
        check("t6_mosi_bits", mosi_bits[15:0], 16'h0F0F);
        check("t6_rx", rx_data, 16'h0F0F);
        check("t6_rx_pulses", rxv_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
